// File: rtl/z_core_sig_dump.sv
// Signature dump engine: waits for CPU halt or a watchdog, then reads an
// address range over AXI-Lite and streams each word out on a valid/ready port.
module z_core_sig_dump #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    sig_begin,
    input  logic [ADDR_WIDTH-1:0]    sig_end,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
    input  logic                     halt,
    output logic [ADDR_WIDTH-1:0]    m_axil_araddr,
    output logic [2:0]               m_axil_arprot,
    output logic                     m_axil_arvalid,
    input  logic                     m_axil_arready,
    input  logic [DATA_WIDTH-1:0]    m_axil_rdata,
    input  logic [1:0]               m_axil_rresp,
    input  logic                     m_axil_rvalid,
    output logic                     m_axil_rready,
    output logic [DATA_WIDTH-1:0]    sig_data,
    output logic [ADDR_WIDTH-1:0]    sig_addr,
    output logic                     sig_valid,
    input  logic                     sig_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     timed_out,
    output logic                     err,
    output logic [TIMEOUT_WIDTH-1:0] cycle_count,
    output logic [ADDR_WIDTH-1:0]    word_count
);

    localparam int unsigned OFFS_W = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
    localparam int unsigned EXT_W  = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFS_W;
    localparam logic [EXT_W-1:0]      STEP       = EXT_W'(STRB_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_AR,
        ST_R,
        ST_OUT,
        ST_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [EXT_W-1:0]         cur_q, cur_d;
    logic [EXT_W-1:0]         end_q, end_d;
    logic [TIMEOUT_WIDTH-1:0] timeout_q, timeout_d;
    logic [TIMEOUT_WIDTH-1:0] cycle_count_q, cycle_count_d;
    logic [ADDR_WIDTH-1:0]    word_count_q, word_count_d;
    logic [ADDR_WIDTH-1:0]    araddr_q, araddr_d;
    logic [ADDR_WIDTH-1:0]    sig_addr_q, sig_addr_d;
    logic [DATA_WIDTH-1:0]    sig_data_q, sig_data_d;
    logic                     arvalid_q, arvalid_d;
    logic                     rready_q, rready_d;
    logic                     sig_valid_q, sig_valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     timed_out_q, timed_out_d;
    logic                     err_q, err_d;

    // Extended-width next address and saturating run-cycle increment
    logic [EXT_W-1:0]         cur_next;
    logic [TIMEOUT_WIDTH-1:0] cycle_inc;
    logic                     wd_fire;

    // Helper arithmetic shared by the next-state logic
    always_comb begin
        cur_next  = cur_q + STEP;
        cycle_inc = (&cycle_count_q) ? cycle_count_q : cycle_count_q + TIMEOUT_WIDTH'(1);
        wd_fire   = (timeout_q != '0) && (cycle_inc >= timeout_q);
    end

    // Next-state, datapath updates and registered output views
    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        end_d         = end_q;
        timeout_d     = timeout_q;
        cycle_count_d = cycle_count_q;
        word_count_d  = word_count_q;
        araddr_d      = araddr_q;
        sig_addr_d    = sig_addr_q;
        sig_data_d    = sig_data_q;
        timed_out_d   = timed_out_q;
        err_d         = err_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d       = ST_RUN;
                    cur_d         = {1'b0, sig_begin & ALIGN_MASK};
                    end_d         = {1'b0, sig_end & ALIGN_MASK};
                    timeout_d     = timeout_cycles;
                    cycle_count_d = '0;
                    word_count_d  = '0;
                    err_d         = 1'b0;
                    timed_out_d   = 1'b0;
                end
            end
            ST_RUN: begin
                cycle_count_d = cycle_inc;
                if (halt || wd_fire) begin
                    // halt takes precedence; watchdog is only reported when alone
                    timed_out_d = wd_fire && !halt;
                    state_d     = (cur_q < end_q) ? ST_AR : ST_DONE;
                end
            end
            ST_AR: begin
                if (arvalid_q && m_axil_arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (rready_q && m_axil_rvalid) begin
                    state_d    = ST_OUT;
                    sig_data_d = m_axil_rdata;
                    sig_addr_d = cur_q[ADDR_WIDTH-1:0];
                    err_d      = err_q | (m_axil_rresp != 2'b00);
                end
            end
            ST_OUT: begin
                if (sig_ready) begin
                    word_count_d = word_count_q + ADDR_WIDTH'(1);
                    cur_d        = cur_next;
                    state_d      = (cur_next < end_q) ? ST_AR : ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        arvalid_d   = (state_d == ST_AR);
        rready_d    = (state_d == ST_R);
        sig_valid_d = (state_d == ST_OUT);
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d      = (state_d == ST_DONE);
        if (state_d == ST_AR) begin
            araddr_d = cur_d[ADDR_WIDTH-1:0];
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            cur_q         <= '0;
            end_q         <= '0;
            timeout_q     <= '0;
            cycle_count_q <= '0;
            word_count_q  <= '0;
            araddr_q      <= '0;
            sig_addr_q    <= '0;
            sig_data_q    <= '0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            sig_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timed_out_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            end_q         <= end_d;
            timeout_q     <= timeout_d;
            cycle_count_q <= cycle_count_d;
            word_count_q  <= word_count_d;
            araddr_q      <= araddr_d;
            sig_addr_q    <= sig_addr_d;
            sig_data_q    <= sig_data_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            sig_valid_q   <= sig_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timed_out_q   <= timed_out_d;
            err_q         <= err_d;
        end
    end

    assign m_axil_araddr  = araddr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;
    assign sig_data       = sig_data_q;
    assign sig_addr       = sig_addr_q;
    assign sig_valid      = sig_valid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign timed_out      = timed_out_q;
    assign err            = err_q;
    assign cycle_count    = cycle_count_q;
    assign word_count     = word_count_q;

endmodule

// File: tb/tb_z_core_sig_dump.sv
// Bench for z_core_sig_dump: AXI-Lite memory slave with configurable delays,
// stream sink with optional backpressure, and a range-based scoreboard.
module tb_z_core_sig_dump;

    logic        clk = 1'b0;
    logic        rstn, start, halt;
    logic [31:0] sig_begin, sig_end, timeout_cycles;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid, rready, rvalid = 1'b0, arready = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00;
    logic [31:0] sig_data, sig_addr;
    logic        sig_valid, sig_ready = 1'b1;
    logic        busy, done, timed_out, err;
    logic [31:0] cycle_count, word_count;

    z_core_sig_dump dut (
        .clk(clk), .rstn(rstn), .start(start),
        .sig_begin(sig_begin), .sig_end(sig_end), .timeout_cycles(timeout_cycles),
        .halt(halt),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid),
        .m_axil_arready(arready), .m_axil_rdata(rdata), .m_axil_rresp(rresp),
        .m_axil_rvalid(rvalid), .m_axil_rready(rready),
        .sig_data(sig_data), .sig_addr(sig_addr), .sig_valid(sig_valid),
        .sig_ready(sig_ready), .busy(busy), .done(done), .timed_out(timed_out),
        .err(err), .cycle_count(cycle_count), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Bench configuration, written only by the main process
    int          ar_max = 0, r_min = 0, r_max = 0;
    bit          rand_ready = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    // Handshake recorder (posedge)
    int          cyc = 0, ar_cnt = 0, sb_cnt = 0;
    bit          ar_hs_p = 1'b0, r_hs_p = 1'b0;
    logic [31:0] ar_addr_p = 32'h0;
    int          hs_cyc  [256];
    logic [31:0] hs_data [256];
    logic [31:0] hs_addr [256];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        ar_hs_p   <= rstn && arvalid && arready;
        r_hs_p    <= rstn && rvalid && rready;
        ar_addr_p <= araddr;
        if (rstn && arvalid && arready) ar_cnt <= ar_cnt + 1;
        if (rstn && sig_valid && sig_ready) begin
            hs_cyc[8'(sb_cnt)]  <= cyc;
            hs_data[8'(sb_cnt)] <= sig_data;
            hs_addr[8'(sb_cnt)] <= sig_addr;
            sb_cnt              <= sb_cnt + 1;
        end
    end

    // AXI-Lite read slave with random address/data delays
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          ar_wait = 0, r_wait = 0;
    always @(negedge clk) begin
        if (!rstn) begin
            arready = 1'b0; rvalid = 1'b0; pend = 1'b0; ar_wait = 0; r_wait = 0;
        end else begin
            if (r_hs_p) begin
                pend = 1'b0; rvalid = 1'b0;
            end
            if (ar_hs_p) begin
                pend = 1'b1; pend_addr = ar_addr_p;
                r_wait = int'($urandom_range(r_max, r_min));
                if (ar_max != 0) arready = 1'b0;
                ar_wait = int'($urandom_range(ar_max, 0));
            end
            if (pend && !rvalid) begin
                if (r_wait == 0) begin
                    rvalid = 1'b1;
                    rdata  = mem_word(pend_addr);
                    rresp  = (pend_addr == err_addr) ? 2'b10 : 2'b00;
                end else r_wait--;
            end
            if (arvalid && !arready) begin
                if (ar_wait == 0) arready = 1'b1;
                else ar_wait--;
            end
        end
    end

    // Stream sink
    always @(negedge clk) sig_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;

    // Scoreboard state and counters
    int          errors = 0, checks = 0;
    bit          chk_en = 1'b0;
    logic [31:0] exp_base, exp_end;
    int          exp_n = 0, sb_base = 0, ar_base = 0, start_cyc = 0, first_ar_cyc = -1;

    task automatic check_true(input string name, input bit ok,
                              input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_true(name, act == exp, act, exp);
    endtask

    // Per-cycle comparison of the bus and stream against the expected word list
    task automatic cmp();
        int si, ai;
        logic [31:0] ea;
        if (!rstn || !chk_en) return;
        si = sb_cnt - sb_base;
        ai = ar_cnt - ar_base;
        if (sig_valid) begin
            check_true("stream_overrun", si < exp_n, 64'(si), 64'(exp_n - 1));
            if (si < exp_n) begin
                ea = exp_base + 32'(4 * si);
                check_eq("sig_addr", 64'(sig_addr), 64'(ea));
                check_eq("sig_data", 64'(sig_data), 64'(mem_word(ea)));
            end
        end
        if (arvalid) begin
            if (first_ar_cyc < 0) first_ar_cyc = cyc;
            check_true("ar_overrun", ai < exp_n, 64'(ai), 64'(exp_n - 1));
            if (ai < exp_n) check_eq("araddr", 64'(araddr), 64'(exp_base + 32'(4 * ai)));
            check_true("one_outstanding", ai == si, 64'(ai), 64'(si));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cmp();
    endtask

    task automatic do_start(input logic [31:0] b, input logic [31:0] e, input logic [31:0] to);
        sig_begin = b; sig_end = e; timeout_cycles = to; start = 1'b1;
        exp_base = b & ~32'h3;
        exp_end  = e & ~32'h3;
        exp_n    = (exp_base < exp_end) ? int'((exp_end - exp_base) >> 2) : 0;
        sb_base = sb_cnt; ar_base = ar_cnt; first_ar_cyc = -1; chk_en = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic halt_at(input int k);
        repeat (k - 1) tick();
        halt = 1'b1;
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        int n = 0;
        while (!done && n < max_cyc) begin
            tick();
            n++;
        end
        check_eq({name, "_done"}, 64'(done), 64'(1));
    endtask

    task automatic check_all_zero(input string name);
        check_eq({name, "_arvalid"}, 64'(arvalid), 0);
        check_eq({name, "_rready"}, 64'(rready), 0);
        check_eq({name, "_sig_valid"}, 64'(sig_valid), 0);
        check_eq({name, "_busy"}, 64'(busy), 0);
        check_eq({name, "_done"}, 64'(done), 0);
        check_eq({name, "_timed_out"}, 64'(timed_out), 0);
        check_eq({name, "_err"}, 64'(err), 0);
        check_eq({name, "_araddr"}, 64'(araddr), 0);
        check_eq({name, "_sig_data"}, 64'(sig_data), 0);
        check_eq({name, "_sig_addr"}, 64'(sig_addr), 0);
        check_eq({name, "_cycle_count"}, 64'(cycle_count), 0);
        check_eq({name, "_word_count"}, 64'(word_count), 0);
        check_eq({name, "_arprot"}, 64'(arprot), 0);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; halt = 1'b0;
        sig_begin = '0; sig_end = '0; timeout_cycles = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rstn = 1'b1;
        repeat (2) tick();

        // Basic walk, zero wait states, halt in RUN cycle 5
        do_start(32'h100, 32'h110, 32'd0);
        check_eq("t1_busy_after_start", 64'(busy), 1);
        halt_at(5);
        wait_done(100, "t1");
        halt = 1'b0;
        check_eq("t1_run_len", 64'(first_ar_cyc - start_cyc), 5);
        check_eq("t1_cycle_count", 64'(cycle_count), 5);
        check_eq("t1_word_count", 64'(word_count), 4);
        check_eq("t1_words_seen", 64'(sb_cnt - sb_base), 4);
        check_eq("t1_reads", 64'(ar_cnt - ar_base), 4);
        check_eq("t1_timed_out", 64'(timed_out), 0);
        check_eq("t1_err", 64'(err), 0);
        check_eq("t1_busy", 64'(busy), 0);
        check_eq("t1_first_data", 64'(hs_data[8'(sb_base)]), 64'h5B5A_FEFF);
        check_eq("t1_first_addr", 64'(hs_addr[8'(sb_base)]), 64'h100);
        check_eq("t1_last_addr", 64'(hs_addr[8'(sb_base + 3)]), 64'h10C);
        for (int i = 0; i < 3; i++)
            check_eq("t1_gap", 64'(hs_cyc[8'(sb_base + i + 1)] - hs_cyc[8'(sb_base + i)]), 3);

        // Watchdog alone; restarted from DONE so counters must clear
        do_start(32'h100, 32'h110, 32'd20);
        check_eq("t2_word_count_clr", 64'(word_count), 0);
        check_eq("t2_cycle_count_clr", 64'(cycle_count), 0);
        check_eq("t2_done_clr", 64'(done), 0);
        wait_done(200, "t2");
        check_eq("t2_run_len", 64'(first_ar_cyc - start_cyc), 20);
        check_eq("t2_timed_out", 64'(timed_out), 1);
        check_eq("t2_cycle_count", 64'(cycle_count), 20);
        check_eq("t2_word_count", 64'(word_count), 4);

        // halt and watchdog in the same cycle: halt wins
        do_start(32'h100, 32'h110, 32'd20);
        check_eq("t3_timed_out_clr", 64'(timed_out), 0);
        halt_at(20);
        wait_done(200, "t3");
        halt = 1'b0;
        check_eq("t3_timed_out", 64'(timed_out), 0);
        check_eq("t3_cycle_count", 64'(cycle_count), 20);
        check_eq("t3_run_len", 64'(first_ar_cyc - start_cyc), 20);

        // Error response on 0x104
        err_addr = 32'h104;
        do_start(32'h100, 32'h110, 32'd0);
        halt_at(1);
        wait_done(100, "t5");
        halt = 1'b0;
        err_addr = 32'hFFFF_FFFF;
        check_eq("t5_err", 64'(err), 1);
        check_eq("t5_word_count", 64'(word_count), 4);
        check_eq("t5_err_word", 64'(hs_data[8'(sb_base + 1)]), 64'(mem_word(32'h104)));

        // Random backpressure and slave delays
        ar_max = 7; r_min = 0; r_max = 7; rand_ready = 1'b1;
        do_start(32'h300, 32'h340, 32'd0);
        check_eq("t4_err_clr", 64'(err), 0);
        halt_at(1);
        wait_done(2000, "t4");
        halt = 1'b0;
        ar_max = 0; r_max = 0; rand_ready = 1'b0;
        check_eq("t4_word_count", 64'(word_count), 16);
        check_eq("t4_words_seen", 64'(sb_cnt - sb_base), 16);

        // Unaligned bounds are truncated to word alignment
        do_start(32'h101, 32'h10B, 32'd0);
        halt_at(1);
        wait_done(100, "tu");
        halt = 1'b0;
        check_eq("tu_word_count", 64'(word_count), 2);
        check_eq("tu_last_addr", 64'(hs_addr[8'(sb_base + 1)]), 64'h104);

        // Empty range
        do_start(32'h200, 32'h200, 32'd0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check_eq("te_done_next", 64'(done), 1);
        check_eq("te_busy", 64'(busy), 0);
        repeat (3) tick();
        check_eq("te_reads", 64'(ar_cnt - ar_base), 0);
        check_eq("te_word_count", 64'(word_count), 0);

        // Range at the top of the address space
        do_start(32'hFFFF_FFF8, 32'h0, 32'd0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check_eq("tw_done_next", 64'(done), 1);
        repeat (3) tick();
        check_eq("tw_reads", 64'(ar_cnt - ar_base), 0);
        check_eq("tw_word_count", 64'(word_count), 0);

        // Reset while waiting for read data
        r_min = 50; r_max = 50;
        do_start(32'h100, 32'h110, 32'd0);
        halt = 1'b1;
        begin
            int n = 0;
            while (!rready && n < 20) begin tick(); n++; end
        end
        halt = 1'b0;
        check_eq("tr_in_r", 64'(rready), 1);
        rstn = 1'b0;
        chk_en = 1'b0;
        tick();
        check_all_zero("tr");
        rstn = 1'b1;
        r_min = 0; r_max = 0;
        repeat (2) tick();

        // Normal operation after reset
        do_start(32'h100, 32'h108, 32'd0);
        halt_at(1);
        wait_done(100, "tp");
        halt = 1'b0;
        check_eq("tp_word_count", 64'(word_count), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
